// File: rtl/taillight_seq.sv
// Turn-signal / brake / hazard tail-light sequencer with a stepped lamp ramp per side.
// Brake support is compiled in only when TAILLIGHT_BRAKE_EN is defined.
module taillight_seq #(
  parameter int unsigned LAMPS = 3,
  parameter int unsigned DIV   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left_req,
  input  logic             right_req,
  input  logic             hazard_req,
  input  logic             brake,
  output logic [LAMPS-1:0] left_lamps,
  output logic [LAMPS-1:0] right_lamps,
  output logic [3:0]       state
);

  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned STEP_W = $clog2(LAMPS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LAMPS);

  // Encodings double as the seven-segment mode code driven on state.
  typedef enum logic [3:0] {
    ST_IDLE        = 4'b0000,
    ST_RIGHT       = 4'b0001,
    ST_LEFT        = 4'b0011,
    ST_BRAKE       = 4'b0100,
    ST_BRAKE_RIGHT = 4'b0101,
    ST_BRAKE_LEFT  = 4'b0111,
    ST_HAZ         = 4'b1000
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [LAMPS-1:0]  left_q, left_d, right_q, right_d, ramp;
  logic              brake_en, tick;

`ifdef TAILLIGHT_BRAKE_EN
  assign brake_en = brake;
`else
  logic unused_brake;
  assign unused_brake = brake;
  assign brake_en     = 1'b0;
`endif

  // State register; lamp drives are registered from the next mode/step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // Mode decode, step sequencing and lamp pattern.
  always_comb begin
    mode_d  = ST_IDLE;
    cnt_d   = '0;
    step_d  = '0;
    left_d  = '0;
    right_d = '0;
    ramp    = '0;
    tick    = (cnt_q == CNT_MAX);

    if (hazard_req || (left_req && right_req)) mode_d = ST_HAZ;
    else if (left_req)  mode_d = brake_en ? ST_BRAKE_LEFT  : ST_LEFT;
    else if (right_req) mode_d = brake_en ? ST_BRAKE_RIGHT : ST_RIGHT;
    else if (brake_en)  mode_d = ST_BRAKE;

    // Any mode change restarts the sequence; steady modes hold at step 0.
    if ((mode_d == mode_q) && (mode_q != ST_IDLE) && (mode_q != ST_BRAKE)) begin
      cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
      step_d = step_q;
      if (tick) begin
        if (mode_q == ST_HAZ) step_d = (step_q == '0) ? STEP_W'(1) : '0;
        else                  step_d = (step_q == STEP_MAX) ? '0 : step_q + STEP_W'(1);
      end
    end

    for (int i = 0; i < LAMPS; i++) ramp[i] = (STEP_W'(i) < step_d);

    case (mode_d)
      ST_LEFT:        left_d = ramp;
      ST_RIGHT:       right_d = ramp;
      ST_BRAKE_LEFT:  begin left_d = ramp; right_d = '1; end
      ST_BRAKE_RIGHT: begin right_d = ramp; left_d = '1; end
      ST_BRAKE:       begin left_d = '1; right_d = '1; end
      ST_HAZ:         if (step_d != '0) begin left_d = '1; right_d = '1; end
      default:        ;
    endcase
  end

  assign left_lamps  = left_q;
  assign right_lamps = right_q;
  assign state       = mode_q;

endmodule

// File: tb/tb_taillight_seq.sv
// Directed bench for taillight_seq (LAMPS=3, DIV=4) plus a LAMPS=8, DIV=1 boundary instance.
module tb_taillight_seq;

  logic       clk = 1'b0;
  logic       rst, left_req, right_req, hazard_req, brake;
  logic [2:0] left_lamps, right_lamps;
  logic [3:0] state;
  logic [7:0] left_lamps8, right_lamps8;
  logic [3:0] state8;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  taillight_seq #(.LAMPS(3), .DIV(4)) u_dut (
    .clk(clk), .rst(rst), .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req), .brake(brake),
    .left_lamps(left_lamps), .right_lamps(right_lamps), .state(state)
  );

  taillight_seq #(.LAMPS(8), .DIV(1)) u_dut8 (
    .clk(clk), .rst(rst), .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req), .brake(brake),
    .left_lamps(left_lamps8), .right_lamps(right_lamps8), .state(state8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] st,
                            input logic [31:0] l, input logic [31:0] r);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_left"},  32'(left_lamps), l);
    check({tag, "_right"}, 32'(right_lamps), r);
  endtask

  function automatic logic [31:0] mask(input int k);
    return (32'd1 << k) - 32'd1;
  endfunction

  initial begin
    rst = 1'b1; left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0; brake = 1'b0;
    @(negedge clk); @(negedge clk);
    expect_out("reset", 4'b0000, 0, 0);
    check("reset8", 32'(left_lamps8), 0);

    rst = 1'b0; left_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      expect_out("left", 4'b0011, mask((c / 4) % 4), 0);
      check("left8", 32'(left_lamps8), mask(c % 9));
    end

    // Reset pulse while at step 3, between clock edges.
    #2 rst = 1'b1;
    #1 expect_out("rst_async", 4'b0000, 0, 0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      expect_out("left_resume", 4'b0011, mask(c / 4), 0);
    end

    right_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      expect_out("haz", 4'b1000, ((c / 4) % 2) ? 7 : 0, ((c / 4) % 2) ? 7 : 0);
    end

    left_req = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      expect_out("right", 4'b0001, 0, mask(c / 4));
    end

    brake = 1'b1;
`ifdef TAILLIGHT_BRAKE_EN
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      expect_out("brake_right", 4'b0101, 7, mask(c / 4));
    end
`else
    for (int c = 9; c < 17; c++) begin
      @(negedge clk);
      expect_out("right_nobrake", 4'b0001, 0, mask((c / 4) % 4));
    end
`endif

    right_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
`ifdef TAILLIGHT_BRAKE_EN
      expect_out("brake", 4'b0100, 7, 7);
`else
      expect_out("brake_ign", 4'b0000, 0, 0);
`endif
    end

    brake = 1'b0;
    @(negedge clk);
    expect_out("brake_off", 4'b0000, 0, 0);

    hazard_req = 1'b1; brake = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      expect_out("haz_brake", 4'b1000, (c / 4) ? 7 : 0, (c / 4) ? 7 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
